// File: rtl/afifo_rd_pkg.sv
// Shared types for the async-FIFO read-side drain: buffer occupancy states and depth.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package afifo_rd_pkg;

  // Entries held between the FIFO read port and the downstream interface
  localparam int BUF_DEPTH = 2;

  // Buffer FSM state is the number of words currently held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/afifo_skid_buf.sv
// Two-entry in-order buffer whose FSM state is its occupancy (EMPTY/ONE/FULL).
// Latency: a pushed word is visible on out_dat one cycle after the push edge.
// Backpressure: out_rdy=0 holds the head word stable; the caller must never push while FULL.
module afifo_skid_buf
  import afifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  out_rdy,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output buf_state_t            state
);

  buf_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic                  xfer;

  // A transfer needs a held word and a ready consumer
  assign xfer = (state_q != EMPTY) & out_rdy;

  // State register: occupancy, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state: push raises occupancy, transfer lowers it, both together leave it unchanged
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !xfer)      state_d = FULL;
        else if (!push && xfer) state_d = EMPTY;
      end
      FULL:    if (xfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Storage update: entry 0 is always the oldest word, entry 1 the one behind it
  always_comb begin
    mem_d = mem_q;
    unique case (state_q)
      EMPTY: if (push) mem_d[0] = push_data;
      ONE: begin
        // simultaneous push and transfer: the new word becomes the head directly
        if (push && xfer) mem_d[0] = push_data;
        else if (push)    mem_d[1] = push_data;
      end
      FULL:    if (xfer) mem_d[0] = mem_q[1];
      default: mem_d = mem_q;
    endcase
  end

  // Storage register; cleared on reset so the output reads zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Outputs: valid whenever anything is held, data is the head entry
  always_comb begin
    out_vld = (state_q != EMPTY);
    out_dat = mem_q[0];
    state   = state_q;
  end

endmodule

// File: rtl/afifo_rd_drain.sv
// Drains an async FIFO read port (FWFT) into a valid/ready stream via a 2-entry buffer.
// Latency: one cycle from the rinc cycle to m_valid when the buffer is empty; 1 word/cycle sustained.
// Backpressure: rinc depends only on registered buffer state, so m_ready never reaches rinc combinationally.
// Build option: define AFIFO_RD_CNT_EN to add the pop_cnt port and its wrapping counter.
module afifo_rd_drain
  import afifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  drain_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef AFIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_cnt
`endif
);

  buf_state_t buf_state;

  // Pop whenever allowed, data is present and the buffer has room; never during reset
  always_comb begin
    rinc = drain_en & ~rempty & (buf_state != FULL) & ~rrst;
  end

  afifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .push     (rinc),
    .push_data(rdata),
    .out_rdy  (m_ready),
    .out_vld  (m_valid),
    .out_dat  (m_data),
    .state    (buf_state)
  );

`ifdef AFIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;

  // Next count: one per popped word, wrapping naturally at all-ones
  always_comb begin
    pop_cnt_d = pop_cnt_q;
    if (rinc) pop_cnt_d = pop_cnt_q + 1'b1;
  end

  // Count register, cleared by reset
  always_ff @(posedge rclk) begin
    if (rrst) pop_cnt_q <= '0;
    else      pop_cnt_q <= pop_cnt_d;
  end

  assign pop_cnt = pop_cnt_q;
`else
  // No counter in this build; the empty block keeps CNT_WIDTH referenced
  if (CNT_WIDTH < 1) begin : g_no_cnt
  end
`endif

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: the bench acts as the FWFT FIFO and keeps a queue-based model.
// Latency: checks every cycle on the falling edge against the model.
// Backpressure: m_ready driven by directed scenarios and then randomly.
module tb_afifo_rd_drain;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          drain_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef AFIFO_RD_CNT_EN
  logic [CNT_W-1:0] pop_cnt;
`endif

  always #5 rclk = ~rclk;

  afifo_rd_drain #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .drain_en(drain_en),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef AFIFO_RD_CNT_EN
    ,
    .pop_cnt (pop_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: words still in the FIFO, words held by the block, pop count
  logic [DW-1:0]    fifo[$];
  logic [DW-1:0]    bq[$];
  logic [CNT_W-1:0] cnt;
  logic             hide;      // forces rempty high although words exist

  // Observations taken from the DUT for scenario-level checks
  logic [DW-1:0] delivered[$];
  int            del_cyc[$];
  int            rinc_pulses;
  int            first_rinc_cyc;
  int            cyc;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present FIFO, check outputs mid-cycle, advance model at the edge
  task automatic step();
    logic exp_rinc;
    rempty = hide || (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : '0;
    @(negedge rclk);
    exp_rinc = !rrst && drain_en && !rempty && (bq.size() < 2);
    chk("rinc", {31'b0, rinc}, {31'b0, exp_rinc});
    chk("m_valid", {31'b0, m_valid}, {31'b0, bq.size() != 0});
    if (bq.size() != 0) chk("m_data", m_data, bq[0]);
`ifdef AFIFO_RD_CNT_EN
    chk("pop_cnt", {{(DW-CNT_W){1'b0}}, pop_cnt}, {{(DW-CNT_W){1'b0}}, cnt});
`endif
    if (rinc) begin
      rinc_pulses++;
      if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
    end
    if (!rrst && m_valid && m_ready) begin
      delivered.push_back(m_data);
      del_cyc.push_back(cyc);
    end
    if (rrst) begin
      bq.delete();
      cnt = '0;
    end else begin
      if (bq.size() != 0 && m_ready) void'(bq.pop_front());
      if (exp_rinc) begin
        bq.push_back(fifo.pop_front());
        cnt = cnt + 1'b1;
      end
    end
    @(posedge rclk);
    #1;
    cyc++;
  endtask

  task automatic clear_obs();
    delivered.delete();
    del_cyc.delete();
    rinc_pulses    = 0;
    first_rinc_cyc = -1;
  endtask

  initial begin
    logic [DW-1:0] w;
    cyc = 0;
    cnt = '0;
    hide = 1'b0;
    rrst = 1'b1;
    drain_en = 1'b0;
    m_ready = 1'b0;
    rempty = 1'b1;
    rdata = '0;
    clear_obs();
    @(posedge rclk);
    #1;

    // Reset state: one further cycle in reset with data waiting
    fifo.push_back(32'h1);
    drain_en = 1'b1;
    step();
    chk("reset_m_data", m_data, '0);
    chk("reset_m_valid", {31'b0, m_valid}, 32'd0);
    fifo.delete();

    // Preloaded 1..8, continuous drain
    rrst = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
    clear_obs();
    for (int i = 0; i < 12; i++) step();
    chk("seq8_count", DW'(delivered.size()), 32'd8);
    for (int i = 0; i < 8 && i < delivered.size(); i++) chk("seq8_word", delivered[i], DW'(i + 1));
    if (delivered.size() == 8) begin
      chk("seq8_first_lat", DW'(del_cyc[0] - first_rinc_cyc), 32'd1);
      chk("seq8_back2back", DW'(del_cyc[7] - del_cyc[0]), 32'd7);
    end else begin
      chk("seq8_timing", DW'(delivered.size()), 32'd8);
    end
`ifdef AFIFO_RD_CNT_EN
    chk("seq8_pop_cnt", {28'b0, pop_cnt}, 32'd8);
`endif

    // Stalled consumer with 5 words: only 2 pops, head held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo.push_back(32'hA0 + DW'(i));
    clear_obs();
    for (int i = 0; i < 5; i++) step();
    chk("stall_pulses", DW'(rinc_pulses), 32'd2);
    chk("stall_head", m_data, 32'hA0);
    chk("stall_fifo_left", DW'(fifo.size()), 32'd3);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("stall_count", DW'(delivered.size()), 32'd5);
    for (int i = 0; i < 5 && i < delivered.size(); i++) chk("stall_order", delivered[i], 32'hA0 + DW'(i));

    // Alternating ready with 16 words
    for (int i = 0; i < 16; i++) fifo.push_back(32'hB00 + DW'(i));
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    chk("alt_count", DW'(delivered.size()), 32'd16);
    for (int i = 0; i < 16 && i < delivered.size(); i++) chk("alt_order", delivered[i], 32'hB00 + DW'(i));

    // drain_en drop with one word buffered and FIFO non-empty
    m_ready = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) fifo.push_back(32'hC0 + DW'(i));
    clear_obs();
    step();
    drain_en = 1'b0;
    step();
    chk("drain_off_pulses", DW'(rinc_pulses), 32'd1);
    m_ready = 1'b1;
    step();
    step();
    chk("drain_off_word", (delivered.size() == 1) ? delivered[0] : 32'hDEAD, 32'hC0);
    chk("drain_off_idle", {31'b0, m_valid}, 32'd0);

    // rempty high while a pop would otherwise happen
    drain_en = 1'b1;
    hide = 1'b1;
    clear_obs();
    step();
    chk("hidden_no_pop", DW'(rinc_pulses), 32'd0);
    hide = 1'b0;
    for (int i = 0; i < 4; i++) step();
    fifo.delete();

    // Reset while FULL discards buffered words; resume at next FIFO word
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo.push_back(32'hD0 + DW'(i));
    for (int i = 0; i < 3; i++) step();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    clear_obs();
    chk("rst_full_m_valid", {31'b0, m_valid}, 32'd0);
`ifdef AFIFO_RD_CNT_EN
    chk("rst_full_pop_cnt", {28'b0, pop_cnt}, 32'd0);
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rst_resume_first", (delivered.size() != 0) ? delivered[0] : 32'hDEAD, 32'hD2);
    chk("rst_resume_count", DW'(delivered.size()), 32'd4);

`ifdef AFIFO_RD_CNT_EN
    // 17 pops into a 4-bit counter wraps to 1
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    for (int i = 0; i < 17; i++) fifo.push_back(DW'(i));
    for (int i = 0; i < 20; i++) step();
    chk("cnt_wrap", {28'b0, pop_cnt}, 32'd1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < $urandom_range(1, 5); k++) begin
          w = $urandom;
          fifo.push_back(w);
        end
      end
      drain_en = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 2) != 0);
      hide     = ($urandom_range(0, 9) == 0);
      rrst     = ($urandom_range(0, 59) == 0);
      step();
    end
    rrst = 1'b0;
    hide = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
